// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - multi-source interrupt controller with fixed priority and ack holdoff
module intr_ctrl #(
  parameter int N_SRC   = 4,
  parameter int HOLDOFF = 16,
  parameter int ID_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] stimulus,
  input  logic [N_SRC-1:0] enable,
  input  logic             intr_ack,
  input  logic [N_SRC-1:0] ack_mask,
  output logic             intr,
  output logic [ID_W-1:0]  intr_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overflow
);

  // HOLDOFF=0 still needs a legal counter width even though the counter is never loaded
  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLDOFF
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ID_W-1:0]  id_nxt;
  logic [ID_W-1:0]  lowest_id;
  logic [N_SRC-1:0] hits;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] live;
  logic             active;

  assign hits   = stimulus & enable;
  assign clr    = intr_ack ? ack_mask : '0;
  assign live   = pending & enable;
  assign active = |live;

  // Descending scan so the lowest index wins
  always_comb begin
    lowest_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (live[i]) lowest_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_nxt    = intr_id;
    case (state)
      S_IDLE: begin
        if (active) begin
          state_nxt = S_ASSERT;
          id_nxt    = lowest_id;
        end
      end
      S_ASSERT: begin
        if (intr_ack) begin
          if (HOLDOFF > 0) begin
            state_nxt = S_HOLDOFF;
            cnt_nxt   = CNT_W'(HOLDOFF - 1);
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (!active) begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A new event wins over a same-cycle clear; overflow is cleared with its pending bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      intr     <= 1'b0;
      intr_id  <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      intr     <= (state_nxt == S_ASSERT);
      intr_id  <= id_nxt;
      pending  <= (pending & ~clr) | hits;
      overflow <= (overflow | (hits & pending)) & ~clr;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - self-checking bench for intr_ctrl, HOLDOFF=16 and HOLDOFF=0 builds side by side
module tb_intr_ctrl;
  localparam int N      = 4;
  localparam int HOLD_A = 16;
  localparam int HOLD_B = 0;
  localparam logic [N-1:0] ALL = 4'hF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] stimulus, enable, ack_mask;
  logic         intr_ack;
  logic         intr_a, intr_b;
  logic [1:0]   id_a, id_b;
  logic [N-1:0] pend_a, pend_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  intr_ctrl #(.N_SRC(N), .HOLDOFF(HOLD_A), .ID_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .stimulus(stimulus), .enable(enable), .intr_ack(intr_ack),
    .ack_mask(ack_mask), .intr(intr_a), .intr_id(id_a), .pending(pend_a), .overflow(ovf_a)
  );

  intr_ctrl #(.N_SRC(N), .HOLDOFF(HOLD_B), .ID_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stimulus(stimulus), .enable(enable), .intr_ack(intr_ack),
    .ack_mask(ack_mask), .intr(intr_b), .intr_id(id_b), .pending(pend_b), .overflow(ovf_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: interrupt line modelled as a flag plus the earliest cycle a new assertion may start
  logic [N-1:0] m_pend, m_ovf;
  logic         m_intr [2];
  logic [1:0]   m_id   [2];
  int           m_start[2];
  int           cyc = 0;

  function automatic logic [1:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_ovf  = '0;
    for (int k = 0; k < 2; k++) begin
      m_intr[k]  = 1'b0;
      m_id[k]    = 2'd0;
      m_start[k] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] st, input logic [N-1:0] en,
                            input logic ack, input logic [N-1:0] am);
    logic [N-1:0] live, clr;
    int           h;
    live = m_pend & en;
    clr  = ack ? am : '0;
    for (int k = 0; k < 2; k++) begin
      h = (k == 0) ? HOLD_A : HOLD_B;
      if (m_intr[k]) begin
        if (ack) begin
          m_intr[k]  = 1'b0;
          m_start[k] = cyc + h + 1;
        end else if (live == '0) begin
          m_intr[k] = 1'b0;
        end
      end else if (cyc >= m_start[k] && live != '0) begin
        m_intr[k] = 1'b1;
        m_id[k]   = lowest(live);
      end
    end
    m_ovf  = (m_ovf | (st & en & m_pend)) & ~clr;
    m_pend = (m_pend & ~clr) | (st & en);
    cyc++;
  endtask

  task automatic compare_all();
    check("intr_a", 32'(intr_a), 32'(m_intr[0]));
    check("id_a",   32'(id_a),   32'(m_id[0]));
    check("pend_a", 32'(pend_a), 32'(m_pend));
    check("ovf_a",  32'(ovf_a),  32'(m_ovf));
    check("intr_b", 32'(intr_b), 32'(m_intr[1]));
    check("id_b",   32'(id_b),   32'(m_id[1]));
    check("pend_b", 32'(pend_b), 32'(m_pend));
    check("ovf_b",  32'(ovf_b),  32'(m_ovf));
  endtask

  task automatic cycle(input logic [N-1:0] st, input logic [N-1:0] en,
                       input logic ack, input logic [N-1:0] am);
    stimulus = st;
    enable   = en;
    intr_ack = ack;
    ack_mask = am;
    @(posedge clk);
    model_step(st, en, ack, am);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, ALL, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_intr_a"}, 32'(intr_a), 32'd0);
    check({tag, "_id_a"},   32'(id_a),   32'd0);
    check({tag, "_pend_a"}, 32'(pend_a), 32'd0);
    check({tag, "_ovf_a"},  32'(ovf_a),  32'd0);
    check({tag, "_intr_b"}, 32'(intr_b), 32'd0);
    check({tag, "_pend_b"}, 32'(pend_b), 32'd0);
  endtask

  initial begin
    logic [N-1:0] st, en, am;
    logic         ack;

    rst_n    = 1'b0;
    stimulus = '0;
    enable   = '0;
    intr_ack = 1'b0;
    ack_mask = '0;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single event latency and ack
    cycle(4'b0100, ALL, 1'b0, '0);
    check("t2_pend", 32'(pend_a), 32'h4);
    check("t2_intr_early", 32'(intr_a), 32'd0);
    cycle('0, ALL, 1'b0, '0);
    check("t2_intr", 32'(intr_a), 32'd1);
    check("t2_id", 32'(id_a), 32'd2);
    cycle('0, ALL, 1'b1, 4'b0100);
    check("t2_intr_ack", 32'(intr_a), 32'd0);
    check("t2_pend_ack", 32'(pend_a), 32'd0);
    idle(20);

    // priority freeze and holdoff length
    cycle(4'b1000, ALL, 1'b0, '0);
    idle(2);
    check("t3_id3", 32'(id_a), 32'd3);
    cycle(4'b0001, ALL, 1'b0, '0);
    cycle('0, ALL, 1'b0, '0);
    check("t3_frozen", 32'(id_a), 32'd3);
    check("t3_intr", 32'(intr_a), 32'd1);
    cycle('0, ALL, 1'b1, 4'b1000);
    check("t3_drop", 32'(intr_a), 32'd0);
    for (int i = 0; i < HOLD_A; i++) begin
      cycle('0, ALL, 1'b0, '0);
      check("t3_holdoff", 32'(intr_a), 32'd0);
    end
    cycle('0, ALL, 1'b0, '0);
    check("t3_reassert", 32'(intr_a), 32'd1);
    check("t3_id0", 32'(id_a), 32'd0);
    cycle('0, ALL, 1'b1, ALL);
    idle(20);

    // overflow and ack/event collision
    cycle(4'b0010, ALL, 1'b0, '0);
    cycle(4'b0010, ALL, 1'b0, '0);
    check("t4_ovf", 32'(ovf_a), 32'h2);
    cycle(4'b0010, ALL, 1'b1, 4'b0010);
    check("t4_pend_kept", 32'(pend_a), 32'h2);
    check("t4_ovf_clr", 32'(ovf_a), 32'h0);
    cycle('0, ALL, 1'b1, ALL);
    idle(20);

    // enable masking
    cycle(4'b0001, 4'b1110, 1'b0, '0);
    check("t5_masked", 32'(pend_a), 32'h0);
    cycle(4'b0100, 4'b1110, 1'b0, '0);
    check("t5_pend", 32'(pend_a), 32'h4);
    cycle('0, 4'b1110, 1'b0, '0);
    check("t5_intr", 32'(intr_a), 32'd1);
    cycle('0, '0, 1'b0, '0);
    check("t5_drop", 32'(intr_a), 32'd0);
    check("t5_pend_kept", 32'(pend_a), 32'h4);
    cycle('0, '0, 1'b1, ALL);
    idle(20);

    // zero-holdoff build: one low cycle after a partial ack
    cycle(4'b0011, ALL, 1'b0, '0);
    cycle('0, ALL, 1'b0, '0);
    check("t6_intr", 32'(intr_b), 32'd1);
    check("t6_id0", 32'(id_b), 32'd0);
    cycle('0, ALL, 1'b1, 4'b0001);
    check("t6_low", 32'(intr_b), 32'd0);
    cycle('0, ALL, 1'b0, '0);
    check("t6_reassert", 32'(intr_b), 32'd1);
    check("t6_id1", 32'(id_b), 32'd1);
    cycle('0, ALL, 1'b1, ALL);
    idle(20);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++) st[b] = ($urandom_range(0, 5) == 0);
      en  = ($urandom_range(0, 9) == 0) ? N'($urandom) : ALL;
      ack = ($urandom_range(0, 5) == 0);
      am  = ($urandom_range(0, 1) == 0) ? ALL : N'($urandom);
      cycle(st, en, ack, am);
    end

    // asynchronous reset while asserted
    cycle('0, ALL, 1'b1, ALL);
    idle(20);
    cycle(4'b0101, ALL, 1'b0, '0);
    cycle('0, ALL, 1'b0, '0);
    check("t1_pre_intr", 32'(intr_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("t1_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
